// File: rtl/dram_response_assembler.sv
// rtl/dram_response_assembler.sv - reassembles out-of-order DRAM read beats into scratchpad rows
module dram_response_assembler #(
  parameter int ID_W   = 8,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 8,
  parameter int SLOTS  = 4,
  parameter int ADDR_W = 10,
  parameter int MASK_W = 32
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       alloc_valid,
  input  logic [ID_W-4:0]            alloc_tag,
  input  logic [ADDR_W-1:0]          alloc_sram_addr,
  input  logic [MASK_W-1:0]          alloc_mask,
  output logic                       alloc_ready,
  input  logic                       dram_rsp_valid,
  input  logic [ID_W-1:0]            dram_rsp_id,
  input  logic [BEAT_W-1:0]          dram_rsp_data,
  output logic                       dram_rsp_ready,
  output logic                       sram_wr_valid,
  input  logic                       sram_wr_ready,
  output logic [ADDR_W-1:0]          sram_wr_addr,
  output logic [MASK_W-1:0]          sram_wr_mask,
  output logic [BEAT_W*BEATS-1:0]    sram_wr_data,
  output logic [ID_W-4:0]            sram_wr_tag,
  output logic                       rsp_err,
  output logic [$clog2(SLOTS):0]     rows_outstanding
);

  localparam int TAG_W  = ID_W - 3;
  localparam int ROW_W  = BEAT_W * BEATS;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int CNT_W  = SLOT_W + 1;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_FILLING = 2'd1,
    SLOT_READY   = 2'd2
  } slot_state_t;

  slot_state_t        state_q  [SLOTS];
  slot_state_t        state_d  [SLOTS];
  logic [TAG_W-1:0]   tag_q    [SLOTS];
  logic [TAG_W-1:0]   tag_d    [SLOTS];
  logic [ADDR_W-1:0]  addr_q   [SLOTS];
  logic [ADDR_W-1:0]  addr_d   [SLOTS];
  logic [MASK_W-1:0]  mask_q   [SLOTS];
  logic [MASK_W-1:0]  mask_d   [SLOTS];
  logic [BEATS-1:0]   bitmap_q [SLOTS];
  logic [BEATS-1:0]   bitmap_d [SLOTS];
  logic [ROW_W-1:0]   data_q   [SLOTS];
  logic [ROW_W-1:0]   data_d   [SLOTS];

  logic               lock_q, lock_d;
  logic [SLOT_W-1:0]  lock_slot_q, lock_slot_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_ready_q;

  logic               free_any, ready_any, hit;
  logic [SLOT_W-1:0]  free_idx, ready_idx, hit_idx, sel_idx;
  logic [TAG_W-1:0]   rsp_tag;
  logic [2:0]         beat_idx;
  logic               alloc_fire, beat_fire, wr_valid, wr_fire;
  logic [BEATS-1:0]   merged;

  assign rsp_tag  = dram_rsp_id[ID_W-1:3];
  assign beat_idx = dram_rsp_id[2:0];

  // Priority scans over registered slot state; iterating downward leaves the lowest index.
  always_comb begin
    free_any  = 1'b0;
    free_idx  = '0;
    ready_any = 1'b0;
    ready_idx = '0;
    hit       = 1'b0;
    hit_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (state_q[i] == SLOT_FREE) begin
        free_any = 1'b1;
        free_idx = SLOT_W'(i);
      end
      if (state_q[i] == SLOT_READY) begin
        ready_any = 1'b1;
        ready_idx = SLOT_W'(i);
      end
      if (state_q[i] == SLOT_FILLING && tag_q[i] == rsp_tag) begin
        hit     = 1'b1;
        hit_idx = SLOT_W'(i);
      end
    end
  end

  // Once a row is presented it stays locked so the write port sees stable fields.
  assign sel_idx    = lock_q ? lock_slot_q : ready_idx;
  assign wr_valid   = lock_q | ready_any;
  assign alloc_fire = alloc_valid & free_any;
  assign beat_fire  = dram_rsp_valid & rsp_ready_q;
  assign wr_fire    = wr_valid & sram_wr_ready;

  // Next-state for slots, output lock, error pulse and occupancy.
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    bitmap_d    = bitmap_q;
    data_d      = data_q;
    lock_d      = lock_q;
    lock_slot_d = lock_slot_q;
    err_d       = 1'b0;
    merged      = bitmap_q[hit_idx] | (BEATS'(1) << beat_idx);

    // Allocation only ever takes a FREE slot, so a same-cycle beat cannot match it.
    if (alloc_fire) begin
      state_d[free_idx]  = SLOT_FILLING;
      tag_d[free_idx]    = alloc_tag;
      addr_d[free_idx]   = alloc_sram_addr;
      mask_d[free_idx]   = alloc_mask;
      bitmap_d[free_idx] = '0;
    end

    if (beat_fire) begin
      if (hit) begin
        err_d = bitmap_q[hit_idx][beat_idx];
        data_d[hit_idx][beat_idx*BEAT_W +: BEAT_W] = dram_rsp_data;
        bitmap_d[hit_idx] = merged;
        if (&merged) begin
          state_d[hit_idx] = SLOT_READY;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (wr_fire) begin
      state_d[sel_idx] = SLOT_FREE;
      lock_d           = 1'b0;
    end else if (wr_valid) begin
      lock_d      = 1'b1;
      lock_slot_d = sel_idx;
    end

    cnt_d = cnt_q + CNT_W'(alloc_fire) - CNT_W'(wr_fire);
  end

  // Control registers: reset discards all in-flight rows and the output lock.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        state_q[i] <= SLOT_FREE;
      end
      lock_q      <= 1'b0;
      lock_slot_q <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      lock_slot_q <= lock_slot_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rsp_ready_q <= 1'b1;
    end
  end

  // Payload registers need no reset; they are only observed while their slot is non-FREE.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    addr_q   <= addr_d;
    mask_q   <= mask_d;
    bitmap_q <= bitmap_d;
    data_q   <= data_d;
  end

  assign alloc_ready      = free_any;
  assign dram_rsp_ready   = rsp_ready_q;
  assign sram_wr_valid    = wr_valid;
  assign sram_wr_addr     = addr_q[sel_idx];
  assign sram_wr_mask     = mask_q[sel_idx];
  assign sram_wr_data     = data_q[sel_idx];
  assign sram_wr_tag      = tag_q[sel_idx];
  assign rsp_err          = err_q;
  assign rows_outstanding = cnt_q;

endmodule

// File: tb/tb_dram_response_assembler.sv
// tb/tb_dram_response_assembler.sv - self-checking bench for dram_response_assembler
module tb_dram_response_assembler;

  localparam int ID_W   = 8;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 8;
  localparam int SLOTS  = 4;
  localparam int ADDR_W = 10;
  localparam int MASK_W = 32;
  localparam int TAG_W  = ID_W - 3;
  localparam int ROW_W  = BEAT_W * BEATS;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              alloc_valid;
  logic [TAG_W-1:0]  alloc_tag;
  logic [ADDR_W-1:0] alloc_sram_addr;
  logic [MASK_W-1:0] alloc_mask;
  logic              alloc_ready;
  logic              dram_rsp_valid;
  logic [ID_W-1:0]   dram_rsp_id;
  logic [BEAT_W-1:0] dram_rsp_data;
  logic              dram_rsp_ready;
  logic              sram_wr_valid;
  logic              sram_wr_ready;
  logic [ADDR_W-1:0] sram_wr_addr;
  logic [MASK_W-1:0] sram_wr_mask;
  logic [ROW_W-1:0]  sram_wr_data;
  logic [TAG_W-1:0]  sram_wr_tag;
  logic              rsp_err;
  logic [2:0]        rows_outstanding;

  always #5 clk = ~clk;

  dram_response_assembler #(
    .ID_W(ID_W), .BEAT_W(BEAT_W), .BEATS(BEATS),
    .SLOTS(SLOTS), .ADDR_W(ADDR_W), .MASK_W(MASK_W)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
    .alloc_sram_addr(alloc_sram_addr), .alloc_mask(alloc_mask),
    .alloc_ready(alloc_ready),
    .dram_rsp_valid(dram_rsp_valid), .dram_rsp_id(dram_rsp_id),
    .dram_rsp_data(dram_rsp_data), .dram_rsp_ready(dram_rsp_ready),
    .sram_wr_valid(sram_wr_valid), .sram_wr_ready(sram_wr_ready),
    .sram_wr_addr(sram_wr_addr), .sram_wr_mask(sram_wr_mask),
    .sram_wr_data(sram_wr_data), .sram_wr_tag(sram_wr_tag),
    .rsp_err(rsp_err), .rows_outstanding(rows_outstanding)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per-slot record of what has arrived; 0 free, 1 filling, 2 ready.
  int                m_st   [SLOTS];
  logic [TAG_W-1:0]  m_tag  [SLOTS];
  logic [ADDR_W-1:0] m_addr [SLOTS];
  logic [MASK_W-1:0] m_mask [SLOTS];
  logic [BEAT_W-1:0] m_beat [SLOTS][BEATS];
  bit                m_got  [SLOTS][BEATS];
  bit                m_lock;
  int                m_lock_slot;
  bit                m_err;
  bit                m_rdy;

  function automatic void model_sel(output bit v, output int s);
    v = 1'b0;
    s = 0;
    if (m_lock) begin
      v = 1'b1;
      s = m_lock_slot;
    end else begin
      for (int i = SLOTS - 1; i >= 0; i--)
        if (m_st[i] == 2) begin v = 1'b1; s = i; end
    end
  endfunction

  task automatic check_outputs();
    int busy;
    bit any_free;
    bit v;
    int s;
    logic [ROW_W-1:0] ed;
    busy = 0;
    any_free = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (m_st[i] == 0) any_free = 1'b1;
      else busy++;
    end
    check("alloc_ready", alloc_ready, any_free);
    check("rows_outstanding", rows_outstanding, busy);
    check("dram_rsp_ready", dram_rsp_ready, m_rdy);
    check("rsp_err", rsp_err, m_err);
    model_sel(v, s);
    check("sram_wr_valid", sram_wr_valid, v);
    if (v) begin
      for (int k = 0; k < BEATS; k++) ed[k*BEAT_W +: BEAT_W] = m_beat[s][k];
      check("sram_wr_addr", sram_wr_addr, m_addr[s]);
      check("sram_wr_mask", sram_wr_mask, m_mask[s]);
      check("sram_wr_tag", sram_wr_tag, m_tag[s]);
      check("sram_wr_data", sram_wr_data, ed);
    end
  endtask

  task automatic model_step();
    bit v;
    int s;
    int fs;
    int hs;
    int k;
    bit e;
    bit all;
    if (!n_rst) begin
      for (int i = 0; i < SLOTS; i++) m_st[i] = 0;
      m_lock = 1'b0;
      m_err  = 1'b0;
      m_rdy  = 1'b0;
      return;
    end
    model_sel(v, s);
    fs = -1;
    hs = -1;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (m_st[i] == 0) fs = i;
      if (m_st[i] == 1 && m_tag[i] == dram_rsp_id[ID_W-1:3]) hs = i;
    end
    e = 1'b0;
    if (dram_rsp_valid && m_rdy) begin
      k = int'(dram_rsp_id[2:0]);
      if (hs < 0) begin
        e = 1'b1;
      end else begin
        if (m_got[hs][k]) e = 1'b1;
        m_got[hs][k]  = 1'b1;
        m_beat[hs][k] = dram_rsp_data;
        all = 1'b1;
        for (int j = 0; j < BEATS; j++) all &= m_got[hs][j];
        if (all) m_st[hs] = 2;
      end
    end
    if (alloc_valid && fs >= 0) begin
      m_st[fs]   = 1;
      m_tag[fs]  = alloc_tag;
      m_addr[fs] = alloc_sram_addr;
      m_mask[fs] = alloc_mask;
      for (int j = 0; j < BEATS; j++) m_got[fs][j] = 1'b0;
    end
    if (v && sram_wr_ready) begin
      m_st[s] = 0;
      m_lock  = 1'b0;
    end else if (v) begin
      m_lock      = 1'b1;
      m_lock_slot = s;
    end
    m_err = e;
    m_rdy = 1'b1;
  endtask

  // One clock: check outputs mid-cycle, advance the model with the held inputs.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [TAG_W-1:0] t, input logic [ADDR_W-1:0] a, input logic [MASK_W-1:0] m);
    alloc_valid = 1'b1;
    alloc_tag = t;
    alloc_sram_addr = a;
    alloc_mask = m;
    cycle();
    alloc_valid = 1'b0;
  endtask

  task automatic do_beat(input logic [TAG_W-1:0] t, input logic [2:0] i, input logic [BEAT_W-1:0] d);
    dram_rsp_valid = 1'b1;
    dram_rsp_id = {t, i};
    dram_rsp_data = d;
    cycle();
    dram_rsp_valid = 1'b0;
  endtask

  logic [ROW_W-1:0] exp_row;
  int               fill_q[$];
  int               ps;
  int               pi;

  initial begin
    n_rst = 1'b0;
    alloc_valid = 1'b0;
    alloc_tag = '0;
    alloc_sram_addr = '0;
    alloc_mask = '0;
    dram_rsp_valid = 1'b0;
    dram_rsp_id = '0;
    dram_rsp_data = '0;
    sram_wr_ready = 1'b0;
    @(posedge clk);
    #1;
    model_step();
    cycle();
    n_rst = 1'b1;
    cycle();

    // Reversed beats, data = index.
    do_alloc(5'd5, 10'h12, 32'hffff_ffff);
    for (int i = 7; i >= 0; i--) do_beat(5'd5, 3'(i), 64'(i));
    for (int k = 0; k < BEATS; k++) exp_row[k*BEAT_W +: BEAT_W] = 64'(k);
    check("rev_valid", sram_wr_valid, 1'b1);
    check("rev_addr", sram_wr_addr, 10'h12);
    check("rev_data", sram_wr_data, exp_row);
    sram_wr_ready = 1'b1;
    cycle();
    sram_wr_ready = 1'b0;
    cycle();

    // Fill all slots, then drain slot 2.
    for (int i = 0; i < 4; i++) do_alloc(5'(i + 1), 10'(32 + i), 32'(32'h1111 * (i + 1)));
    check("full_alloc_ready", alloc_ready, 1'b0);
    check("full_rows", rows_outstanding, 3'd4);
    sram_wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) do_beat(5'd3, 3'(i), {$urandom, $urandom});
    cycle();
    check("freed_alloc_ready", alloc_ready, 1'b1);
    sram_wr_ready = 1'b0;

    // Slot 3 then slot 0 complete while stalled.
    for (int i = 0; i < 8; i++) do_beat(5'd4, 3'(7 - i), {$urandom, $urandom});
    for (int i = 0; i < 8; i++) do_beat(5'd1, 3'(i), {$urandom, $urandom});
    cycle();
    check("stall_tag", sram_wr_tag, 5'd4);
    sram_wr_ready = 1'b1;
    cycle();
    check("next_valid", sram_wr_valid, 1'b1);
    check("next_tag", sram_wr_tag, 5'd1);
    cycle();
    sram_wr_ready = 1'b0;

    // Unmatched beat and duplicate index.
    do_beat(5'd9, 3'd0, 64'hdead);
    check("unmatched_err", rsp_err, 1'b1);
    check("unmatched_rows", rows_outstanding, 3'd1);
    cycle();
    check("err_clears", rsp_err, 1'b0);
    do_beat(5'd2, 3'd2, 64'haaaa_aaaa);
    do_beat(5'd2, 3'd2, 64'hbbbb_bbbb);
    check("dup_err", rsp_err, 1'b1);
    for (int i = 0; i < 8; i++) if (i != 2) do_beat(5'd2, 3'(i), 64'(i));
    check("dup_lane", sram_wr_data[2*BEAT_W +: BEAT_W], 64'hbbbb_bbbb);
    sram_wr_ready = 1'b1;
    cycle();
    sram_wr_ready = 1'b0;

    // Reset while the output is stalled.
    do_alloc(5'd6, 10'h3ff, 32'h0f0f_0f0f);
    for (int i = 0; i < 8; i++) do_beat(5'd6, 3'(i), {$urandom, $urandom});
    cycle();
    check("pre_rst_valid", sram_wr_valid, 1'b1);
    n_rst = 1'b0;
    cycle();
    n_rst = 1'b1;
    check("rst_valid", sram_wr_valid, 1'b0);
    check("rst_rows", rows_outstanding, 3'd0);
    check("rst_alloc_ready", alloc_ready, 1'b1);
    cycle();

    // Randomized traffic with a small tag space to force duplicates and collisions.
    for (int c = 0; c < 4000; c++) begin
      n_rst = ($urandom_range(0, 299) != 0);
      alloc_valid = ($urandom_range(0, 3) == 0);
      alloc_tag = 5'($urandom_range(0, 3));
      alloc_sram_addr = 10'($urandom);
      alloc_mask = $urandom;
      sram_wr_ready = ($urandom_range(0, 2) != 0);
      dram_rsp_data = {$urandom, $urandom};
      fill_q.delete();
      for (int i = 0; i < SLOTS; i++) if (m_st[i] == 1) fill_q.push_back(i);
      if (fill_q.size() == 0 || $urandom_range(0, 9) == 0) begin
        dram_rsp_id = 8'($urandom);
      end else begin
        ps = fill_q[$urandom_range(0, fill_q.size() - 1)];
        pi = $urandom_range(0, 7);
        if ($urandom_range(0, 3) != 0)
          for (int j = 0; j < BEATS; j++) if (!m_got[ps][j]) pi = j;
        dram_rsp_id = {m_tag[ps], 3'(pi)};
      end
      dram_rsp_valid = ($urandom_range(0, 4) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_response_assembler.md
DRAM_RESPONSE_ASSEMBLER -- requirements
Module: dram_response_assembler

Interface
REQ-001 The module SHALL have parameter ID_W, default 8, meaning DRAM response id width; bits [2:0] are the beat index and bits [ID_W-1:3] are the row tag.
REQ-002 The module SHALL have parameter BEAT_W, default 64, meaning DRAM beat data width.
REQ-003 The module SHALL have parameter BEATS, default 8, meaning beats per scratchpad row; ROW_W = BEAT_W*BEATS = 512.
REQ-004 The module SHALL have parameter SLOTS, default 4, meaning assembly slots; SLOT_W = clog2(SLOTS).
REQ-005 The module SHALL have parameters ADDR_W, default 10 (SRAM row address width), and MASK_W, default 32 (per-element write mask width).
REQ-006 Ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  single clock; all state on posedge.
- n_rst  in  1  reset, synchronous, active-low.
- alloc_valid  in  1  register a pending DRAM-read row.
- alloc_tag  in  ID_W-3  row tag.
- alloc_sram_addr  in  ADDR_W  destination SRAM row.
- alloc_mask  in  MASK_W  destination element mask.
- alloc_ready  out  1  a FREE slot exists.
- dram_rsp_valid  in  1  DRAM read beat present.
- dram_rsp_id  in  ID_W  {tag, beat index}.
- dram_rsp_data  in  BEAT_W  beat data.
- dram_rsp_ready  out  1  beat accept.
- sram_wr_valid  out  1  assembled row available.
- sram_wr_ready  in  1  SRAM write-port accept.
- sram_wr_addr  out  ADDR_W.
- sram_wr_mask  out  MASK_W.
- sram_wr_data  out  ROW_W.
- sram_wr_tag  out  ID_W-3.
- rsp_err  out  1  one-cycle pulse: unmatched or duplicate beat.
- rows_outstanding  out  SLOT_W+1  count of non-FREE slots.

Function
REQ-007 Each slot SHALL hold state FREE/FILLING/READY, plus tag, addr, mask, a BEATS-bit arrival bitmap and ROW_W of data.
REQ-008 alloc_ready SHALL equal "any slot FREE", evaluated on current registered state; a slot freed in cycle T is not allocatable until T+1.
REQ-009 On alloc_valid && alloc_ready, the lowest-index FREE slot SHALL become FILLING at the next edge, capturing tag, addr and mask, with bitmap cleared.
REQ-010 dram_rsp_ready SHALL be 1 whenever n_rst was high at the last edge; beats are never back-pressured.
REQ-011 On an accepted beat whose tag matches a FILLING slot: data SHALL be written to lane [idx*BEAT_W +: BEAT_W] and bitmap[idx] set; beats may arrive in any order.
REQ-012 An accepted beat with no matching FILLING slot SHALL be dropped with rsp_err=1 the next cycle; a beat whose bitmap bit is already set SHALL overwrite the lane with rsp_err=1.
REQ-013 When the bitmap becomes all-ones (last beat accepted at edge T), the slot SHALL be READY from T+1.
REQ-014 An alloc and a beat for the same newly allocated tag in the same cycle SHALL NOT match; the beat is treated as unmatched.
REQ-015 Output selection: when unlocked, the lowest-index READY slot SHALL be selected and locked; sram_wr_valid=1 and all sram_wr_* fields SHALL be driven from the locked slot and held stable until sram_wr_ready.
REQ-016 On sram_wr_valid && sram_wr_ready, the locked slot SHALL become FREE and the lock SHALL release at the next edge; a new selection may present in that same next cycle (1 row/cycle throughput).
REQ-017 Latency: last beat at edge T -> sram_wr_valid high in cycle T+1 if unlocked and the slot is the lowest READY slot.
REQ-018 rows_outstanding SHALL update at the edge and change by alloc(+1) and release(-1) simultaneously; the net change is 0 when both occur.
REQ-019 A duplicate tag allocation while that tag is FILLING SHALL be accepted into a new slot; beats match the lowest-index FILLING slot with that tag.

Reset
REQ-020 While n_rst=0 at a clock edge, all slots SHALL become FREE, lock SHALL clear, and sram_wr_valid=0, rsp_err=0, rows_outstanding=0, dram_rsp_ready=0; in-flight rows are discarded, and reset mid-stall SHALL drop sram_wr_valid the next cycle.

Verification
REQ-021 Alloc tag 5, addr 0x12, mask all-ones; beats idx 7..0 reversed, data = idx -> sram_wr_valid one cycle after the 8th beat, addr 0x12, lane k = k.
REQ-022 Fill all 4 slots -> alloc_ready=0, rows_outstanding=4; complete slot 2 with sram_wr_ready=1 -> alloc_ready=1 one cycle after the write handshake.
REQ-023 Complete slots 3 then 0 while sram_wr_ready=0 -> output stays locked on slot 3 with stable data; raise ready -> slot 3 is written, then slot 0 in the next cycle.
REQ-024 Send a beat with tag 9 when none is allocated -> rsp_err pulses one cycle, no state change; send a repeated idx 2 -> lane 2 overwritten and rsp_err pulses.
REQ-025 Hold sram_wr_valid stalled, assert n_rst=0 for one edge -> sram_wr_valid=0, rows_outstanding=0, alloc_ready=1 after release.
